otter_dmem_bridge: RTL
======================

Name: otter_dmem_bridge

Overview:
- Data-side memory/peripheral stage driven directly by the otter_mcu dmem port (re/we/sel/addr/w_data); returns read data on i_dmem_r_data.
- Decodes each access to one of three targets: word RAM, a byte TX FIFO, or a machine timer.
- The timer's compare interrupt feeds the core's interrupt input.

Parameters:
- RAM_DEPTH, 1024, RAM size in 32-bit words; power of 2.
- FIFO_DEPTH, 8, TX FIFO entries; power of 2, at least 2.
- MMIO_BASE, 32'h1100_0000, base address of the peripheral window (16 bytes).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_dmem_re  in  1  read strobe
- i_dmem_we  in  1  write strobe
- i_dmem_sel  in  4  byte enables for writes; bit n covers w_data[8n+7:8n]
- i_dmem_addr  in  32  byte address; bits [1:0] ignored
- i_dmem_w_data  in  32  write data
- o_dmem_r_data  out  32  registered read data
- o_tx_valid  out  1  TX FIFO head valid
- o_tx_data  out  8  TX FIFO head byte
- i_tx_ready  in  1  consumer accepts head when o_tx_valid is high
- o_timer_irq  out  1  timer interrupt level

Behaviour:
- Clock and reset: single clock i_clk. i_rst is synchronous and active-high. All state updates on the rising edge of i_clk.
- Reset values:
  - o_dmem_r_data = 0, o_tx_valid = 0, o_tx_data = 0, o_timer_irq = 0.
  - FIFO empty, overflow flag = 0, mtime = 0, mtimecmp = 32'hFFFF_FFFF.
  - RAM contents are not reset.
- Reset mid-operation: empties the FIFO (queued bytes lost) and discards any read in flight.
- Decode:
  - RAM when addr < RAM_DEPTH*4; word index = addr[log2(RAM_DEPTH)+1:2].
  - MMIO when addr[31:4] == MMIO_BASE[31:4]. Registers by offset:
    - 0x0 TX_DATA
    - 0x4 STATUS
    - 0x8 MTIME
    - 0xC MTIMECMP
  - Anything else is unmapped: reads return 0, writes are ignored.
- Read latency:
  - Exactly 1 cycle. o_dmem_r_data is updated the cycle after re=1 and holds its value while re=0.
  - Always returns the full 32-bit word regardless of sel; the core extracts bytes.
- Write: takes effect at the clock edge of the cycle with we=1. Only bytes with sel=1 are modified (RAM, MTIME, MTIMECMP).
- re and we together at the same address: the read returns the pre-write value (read-before-write).
- TX_DATA:
  - A write with sel[0]=1 pushes w_data[7:0]; sel[0]=0 means no push.
  - Reads of TX_DATA return 0.
- STATUS:
  - Read value = {29'b0, overflow, full, empty}.
  - Writing 1 to bit2 with sel[0]=1 clears overflow.
- FIFO:
  - Pop occurs when o_tx_valid && i_tx_ready.
  - Fullness is judged on the count before any same-cycle pop. A push while full is dropped and sets overflow (sticky), even if a pop happens in the same cycle.
  - Push and pop in the same cycle, not full and not empty: count unchanged, data ordered correctly.
  - o_tx_valid = !empty. o_tx_data = head entry, and is 0 when empty.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Timer:
  - mtime increments by 1 every cycle and wraps from 32'hFFFF_FFFF to 0.
  - A write to MTIME overrides that cycle's increment: next value = merged write data.
  - o_timer_irq is registered: it equals (mtime >= mtimecmp, unsigned) evaluated on the previous cycle's register values.
  - Writing MTIMECMP above mtime deasserts the irq one cycle after the write lands.

Optional Feature:
- Macro: OTTER_DMEM_TIMER_EN.
- Defined: timer behaves as above.
- Undefined:
  - No mtime or mtimecmp registers are instantiated.
  - Reads at 0x8 and 0xC return 0; writes there are ignored.
  - o_timer_irq is tied to 0.
  - RAM and FIFO behaviour is unchanged.

Test Plan:
- RAM byte-enable write: write 32'hDEADBEEF to 0x10 with sel=4'hF, then 32'h000000AA with sel=4'b0001, then read 0x10 → 32'hDEADBEAA one cycle after re. Same-cycle re+we at 0x10 → old value returned.
- FIFO full and overflow:
  - Hold i_tx_ready=0 and push bytes 1..9 to TX_DATA.
  - Read STATUS → 32'h6 (full and overflow set).
  - Raise i_tx_ready → o_tx_data emits 1..8 on consecutive cycles, then o_tx_valid=0.
  - Write STATUS = 4 with sel[0]=1 → STATUS reads 32'h1.
- Simultaneous push and pop at count 3 → count stays 3; output order preserved.
- Timer (macro defined):
  - Write MTIMECMP=20 at cycle 0 from reset → o_timer_irq rises at the first cycle after mtime reaches 20.
  - Write MTIME=5 → irq drops one cycle later; a subsequent MTIME read shows the increment resuming from 5.
- Wrap: write MTIME=32'hFFFF_FFFE → reads 32'hFFFF_FFFF, then 0, on the next cycles.
- Unmapped access: read 0x2000_0000 → 0; write there → no RAM, FIFO or timer state change. Assert i_rst during FIFO drain → o_tx_valid=0 and STATUS=1 after the reset edge.

Source files
------------

// File: rtl/otter_dmem_bridge.sv
// otter_dmem_bridge: data-side memory/peripheral stage for the otter_mcu dmem port.
// Decodes each access to word RAM, a byte TX FIFO, or an optional machine timer.
//
// Optional feature macro: OTTER_DMEM_TIMER_EN
//   defined   -> mtime/mtimecmp registers and a registered compare interrupt
//   undefined -> no timer state; MTIME/MTIMECMP read 0, writes ignored, irq tied 0
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_dmem_re/we      read / write strobes
//   i_dmem_sel        write byte enables (bit n -> w_data[8n+7:8n])
//   i_dmem_addr       byte address, bits [1:0] ignored
//   i_dmem_w_data     write data
//   o_dmem_r_data     read data, valid the cycle after re, held while re=0
//   o_tx_valid/data   TX FIFO head (data is 0 when empty)
//   i_tx_ready        consumer pops the head when o_tx_valid is high
//   o_timer_irq       timer interrupt level (mtime >= mtimecmp, one cycle late)
//
// MMIO window (16 bytes at MMIO_BASE): 0x0 TX_DATA, 0x4 STATUS, 0x8 MTIME, 0xC MTIMECMP.
module otter_dmem_bridge #(
  parameter int unsigned RAM_DEPTH  = 1024,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'h1100_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_dmem_re,
  input  logic        i_dmem_we,
  input  logic [3:0]  i_dmem_sel,
  input  logic [31:0] i_dmem_addr,
  input  logic [31:0] i_dmem_w_data,
  output logic [31:0] o_dmem_r_data,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_ready,
  output logic        o_timer_irq
);

  localparam int unsigned RAM_AW    = $clog2(RAM_DEPTH);
  localparam int unsigned FIFO_AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = FIFO_AW + 1;
  localparam logic [31:0] RAM_BYTES = 32'(RAM_DEPTH * 4);

  localparam logic [1:0] OFF_TX       = 2'd0;
  localparam logic [1:0] OFF_STATUS   = 2'd1;
  localparam logic [1:0] OFF_MTIME    = 2'd2;
  localparam logic [1:0] OFF_MTIMECMP = 2'd3;

  // ---------------------------------------------------------------- decode
  logic              w_ram_hit;
  logic              w_mmio_hit;
  logic [1:0]        w_off;
  logic [RAM_AW-1:0] w_ram_idx;

  assign w_ram_hit  = (i_dmem_addr < RAM_BYTES);
  assign w_mmio_hit = !w_ram_hit && (i_dmem_addr[31:4] == MMIO_BASE[31:4]);
  assign w_off      = i_dmem_addr[3:2];
  assign w_ram_idx  = i_dmem_addr[RAM_AW+1:2];

  // ---------------------------------------------------------------- RAM (not reset)
  logic [31:0] r_ram [RAM_DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_dmem_we && w_ram_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (i_dmem_sel[b]) r_ram[w_ram_idx][8*b +: 8] <= i_dmem_w_data[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------- TX FIFO
  logic [7:0]         r_fifo [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_ovf;
  logic               r_tx_valid;
  logic [7:0]         r_tx_data;

  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic               w_push_req;
  logic               w_push;
  logic               w_drop;
  logic               w_ovf_clr;
  logic [FIFO_AW-1:0] w_rd_ptr_nxt;
  logic [CNT_W-1:0]   w_count_nxt;
  logic [7:0]         w_head_nxt;

  assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_pop      = r_tx_valid && i_tx_ready;
  assign w_push_req = i_dmem_we && w_mmio_hit && (w_off == OFF_TX) && i_dmem_sel[0];
  // Fullness uses the pre-pop count, so a push to a full FIFO is dropped even with a pop.
  assign w_push     = w_push_req && !w_full;
  assign w_drop     = w_push_req && w_full;
  assign w_ovf_clr  = i_dmem_we && w_mmio_hit && (w_off == OFF_STATUS) &&
                      i_dmem_sel[0] && i_dmem_w_data[2];

  assign w_rd_ptr_nxt = w_pop ? (r_rd_ptr + FIFO_AW'(1)) : r_rd_ptr;
  assign w_count_nxt  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  // Next head: the byte being pushed lands at the head only when it becomes the sole entry.
  always_comb begin
    w_head_nxt = 8'd0;
    if (w_count_nxt != '0) begin
      if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) w_head_nxt = i_dmem_w_data[7:0];
      else                                      w_head_nxt = r_fifo[w_rd_ptr_nxt];
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= i_dmem_w_data[7:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'd0;
    end else begin
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_count    <= w_count_nxt;
      r_tx_valid <= (w_count_nxt != '0);
      r_tx_data  <= w_head_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      if (w_drop)         r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
    end
  end

  assign o_tx_valid = r_tx_valid;
  assign o_tx_data  = r_tx_data;

  // ---------------------------------------------------------------- timer
  logic [31:0] w_mtime_rd;
  logic [31:0] w_mtimecmp_rd;

`ifdef OTTER_DMEM_TIMER_EN
  logic [31:0] r_mtime;
  logic [31:0] r_mtimecmp;
  logic        r_irq;
  logic        w_mtime_wr;
  logic        w_mtimecmp_wr;

  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) res[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return res;
  endfunction

  assign w_mtime_wr    = i_dmem_we && w_mmio_hit && (w_off == OFF_MTIME);
  assign w_mtimecmp_wr = i_dmem_we && w_mmio_hit && (w_off == OFF_MTIMECMP);

  // A write to MTIME replaces that cycle's increment.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mtime    <= 32'd0;
      r_mtimecmp <= 32'hFFFF_FFFF;
      r_irq      <= 1'b0;
    end else begin
      r_irq   <= (r_mtime >= r_mtimecmp);
      r_mtime <= w_mtime_wr ? f_merge(r_mtime, i_dmem_w_data, i_dmem_sel)
                            : (r_mtime + 32'd1);
      if (w_mtimecmp_wr) r_mtimecmp <= f_merge(r_mtimecmp, i_dmem_w_data, i_dmem_sel);
    end
  end

  assign w_mtime_rd    = r_mtime;
  assign w_mtimecmp_rd = r_mtimecmp;
  assign o_timer_irq   = r_irq;
`else
  assign w_mtime_rd    = 32'd0;
  assign w_mtimecmp_rd = 32'd0;
  assign o_timer_irq   = 1'b0;
`endif

  // ---------------------------------------------------------------- read path
  logic [31:0] w_rd_data;
  logic [31:0] r_rdata;

  always_comb begin
    w_rd_data = 32'd0;
    if (w_ram_hit) begin
      w_rd_data = r_ram[w_ram_idx];
    end else if (w_mmio_hit) begin
      case (w_off)
        OFF_STATUS:   w_rd_data = {29'd0, r_ovf, w_full, w_empty};
        OFF_MTIME:    w_rd_data = w_mtime_rd;
        OFF_MTIMECMP: w_rd_data = w_mtimecmp_rd;
        default:      w_rd_data = 32'd0;
      endcase
    end
  end

  // Register samples pre-write state, giving read-before-write on same-cycle re+we.
  always_ff @(posedge i_clk) begin
    if (i_rst)          r_rdata <= 32'd0;
    else if (i_dmem_re) r_rdata <= w_rd_data;
  end

  assign o_dmem_r_data = r_rdata;

endmodule
